// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: X_m' = X_m + W*X_n, X_n' = X_m - W*X_n.
// Three register stages with a global-advance valid/ready pipeline, optional 1/2 scaling and saturation.
module fft_butterfly_pipe #(
   parameter int DATA_W = 12,
   parameter int TW_W   = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_xm_re,
   input  logic signed [DATA_W-1:0] in_xm_im,
   input  logic signed [DATA_W-1:0] in_xn_re,
   input  logic signed [DATA_W-1:0] in_xn_im,
   input  logic signed [TW_W-1:0]   tw_re,
   input  logic signed [TW_W-1:0]   tw_im,
   input  logic                     in_scale,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_xm_re,
   output logic signed [DATA_W-1:0] out_xm_im,
   output logic signed [DATA_W-1:0] out_xn_re,
   output logic signed [DATA_W-1:0] out_xn_im,
   output logic                     out_sat,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   localparam int P_W = DATA_W + TW_W;
   localparam int T_W = P_W + 1;
   localparam int A_W = T_W + 1;

   localparam logic signed [T_W-1:0] RND   = T_W'(1) <<< (TW_W - 2);
   localparam logic signed [A_W-1:0] MAX_A = (A_W'(1) <<< (DATA_W - 1)) - A_W'(1);
   localparam logic signed [A_W-1:0] MIN_A = -(A_W'(1) <<< (DATA_W - 1));

   logic en;
   logic v1, v2, v3;

   logic signed [DATA_W-1:0] xm_re_s1, xm_im_s1, xn_re_s1, xn_im_s1;
   logic signed [TW_W-1:0]   tw_re_s1, tw_im_s1;
   logic                     scale_s1;

   logic signed [P_W-1:0]    p_rr, p_ii, p_ri, p_ir;
   logic signed [DATA_W-1:0] xm_re_s2, xm_im_s2;
   logic                     scale_s2;

   logic signed [T_W-1:0]    t_re, t_im, t_re_q, t_im_q;
   logic signed [A_W-1:0]    sum_val [4];
   logic signed [A_W-1:0]    scl_val [4];
   logic [DATA_W-1:0]        clip_val [4];
   logic [3:0]               clip_hit;
   logic                     sat_any;

   logic [DATA_W-1:0]        res_reg [4];

   // One enable for every stage: the pipe moves only when the output slot is free or being drained.
   assign en        = !v3 || out_ready;
   assign in_ready  = en;
   assign out_valid = v3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1       <= 1'b0;
         xm_re_s1 <= '0;
         xm_im_s1 <= '0;
         xn_re_s1 <= '0;
         xn_im_s1 <= '0;
         tw_re_s1 <= '0;
         tw_im_s1 <= '0;
         scale_s1 <= 1'b0;
      end else if (en) begin
         v1       <= in_valid;
         xm_re_s1 <= in_xm_re;
         xm_im_s1 <= in_xm_im;
         xn_re_s1 <= in_xn_re;
         xn_im_s1 <= in_xn_im;
         tw_re_s1 <= tw_re;
         tw_im_s1 <= tw_im;
         scale_s1 <= in_scale;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2       <= 1'b0;
         p_rr     <= '0;
         p_ii     <= '0;
         p_ri     <= '0;
         p_ir     <= '0;
         xm_re_s2 <= '0;
         xm_im_s2 <= '0;
         scale_s2 <= 1'b0;
      end else if (en) begin
         v2       <= v1;
         p_rr     <= P_W'(xn_re_s1) * P_W'(tw_re_s1);
         p_ii     <= P_W'(xn_im_s1) * P_W'(tw_im_s1);
         p_ri     <= P_W'(xn_re_s1) * P_W'(tw_im_s1);
         p_ir     <= P_W'(xn_im_s1) * P_W'(tw_re_s1);
         xm_re_s2 <= xm_re_s1;
         xm_im_s2 <= xm_im_s1;
         scale_s2 <= scale_s1;
      end
   end

   // Complex product, then back to sample scale with round-half-up (arithmetic shift floors).
   assign t_re   = T_W'(p_rr) - T_W'(p_ii);
   assign t_im   = T_W'(p_ri) + T_W'(p_ir);
   assign t_re_q = (t_re + RND) >>> (TW_W - 1);
   assign t_im_q = (t_im + RND) >>> (TW_W - 1);

   // Lanes: 0 = xm_re, 1 = xm_im, 2 = xn_re, 3 = xn_im.
   assign sum_val[0] = A_W'(xm_re_s2) + A_W'(t_re_q);
   assign sum_val[1] = A_W'(xm_im_s2) + A_W'(t_im_q);
   assign sum_val[2] = A_W'(xm_re_s2) - A_W'(t_re_q);
   assign sum_val[3] = A_W'(xm_im_s2) - A_W'(t_im_q);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign scl_val[gi]  = scale_s2 ? ((sum_val[gi] + A_W'(1)) >>> 1) : sum_val[gi];
         assign clip_hit[gi] = (scl_val[gi] > MAX_A) || (scl_val[gi] < MIN_A);
         assign clip_val[gi] = (scl_val[gi] > MAX_A) ? MAX_A[DATA_W-1:0] :
                               (scl_val[gi] < MIN_A) ? MIN_A[DATA_W-1:0] :
                                                       scl_val[gi][DATA_W-1:0];
      end
   endgenerate

   assign sat_any = |clip_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3      <= 1'b0;
         out_sat <= 1'b0;
         for (int i = 0; i < 4; i++) res_reg[i] <= '0;
      end else if (en) begin
         v3      <= v2;
         out_sat <= v2 && sat_any;
         for (int i = 0; i < 4; i++) res_reg[i] <= clip_val[i];
      end
   end

   // Sticky flag: a saturating load into the output stage beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (en && v2 && sat_any) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

   assign out_xm_re = res_reg[0];
   assign out_xm_im = res_reg[1];
   assign out_xn_re = res_reg[2];
   assign out_xn_im = res_reg[3];

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Scoreboard bench for fft_butterfly_pipe: an integer model predicts each accepted pair,
// results are popped and compared as the DUT hands them over.
module tb_fft_butterfly_pipe;

   localparam int DW = 12;
   localparam int TW = 12;

   typedef struct {
      int xr;
      int xi;
      int nr;
      int ni;
      bit sat;
   } exp_t;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_xm_re, in_xm_im, in_xn_re, in_xn_im;
   logic signed [TW-1:0] tw_re, tw_im;
   logic                 in_scale;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_xm_re, out_xm_im, out_xn_re, out_xn_im;
   logic                 out_sat;
   logic                 ovf;
   logic                 ovf_clr;

   fft_butterfly_pipe #(.DATA_W(DW), .TW_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_xm_re  (in_xm_re),
      .in_xm_im  (in_xm_im),
      .in_xn_re  (in_xn_re),
      .in_xn_im  (in_xn_im),
      .tw_re     (tw_re),
      .tw_im     (tw_im),
      .in_scale  (in_scale),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_xm_re (out_xm_re),
      .out_xm_im (out_xm_im),
      .out_xn_re (out_xn_re),
      .out_xn_im (out_xn_im),
      .out_sat   (out_sat),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   int   d_xmr, d_xmi, d_xnr, d_xni, d_twr, d_twi;
   bit   d_sc;
   bit   use_ov;
   exp_t ov;
   int   cyc, first_acc, first_out, last_out, out_cnt;
   bit   stall_hold;
   logic [63:0] held;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint fdiv(input longint x, input longint d);
      longint q;
      q = x / d;
      if ((x % d != 0) && (x < 0)) q = q - 1;
      return q;
   endfunction

   function automatic exp_t model(input int xmr, input int xmi, input int xnr, input int xni,
                                  input int twr, input int twi, input bit sc);
      exp_t   e;
      longint tr, ti, hi, lo, one_q;
      longint r[4];
      hi    = (longint'(1) << (DW - 1)) - 1;
      lo    = -(longint'(1) << (DW - 1));
      one_q = longint'(1) << (TW - 1);
      tr = fdiv(longint'(xnr) * twr - longint'(xni) * twi + one_q / 2, one_q);
      ti = fdiv(longint'(xnr) * twi + longint'(xni) * twr + one_q / 2, one_q);
      r[0] = xmr + tr;
      r[1] = xmi + ti;
      r[2] = xmr - tr;
      r[3] = xmi - ti;
      e.sat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (sc) r[i] = fdiv(r[i] + 1, 2);
         if (r[i] > hi) begin
            r[i] = hi;
            e.sat = 1'b1;
         end else if (r[i] < lo) begin
            r[i] = lo;
            e.sat = 1'b1;
         end
      end
      e.xr = int'(r[0]);
      e.xi = int'(r[1]);
      e.nr = int'(r[2]);
      e.ni = int'(r[3]);
      return e;
   endfunction

   function automatic logic [63:0] out_word();
      return {15'd0, out_sat, out_xm_re, out_xm_im, out_xn_re, out_xn_im};
   endfunction

   task automatic set_data(input int a, input int b, input int c, input int d,
                           input int e, input int f, input bit s);
      d_xmr = a; d_xmi = b; d_xnr = c; d_xni = d; d_twr = e; d_twi = f; d_sc = s;
   endtask

   task automatic rand_data();
      set_data(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
               int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
               int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
               1'($urandom_range(0, 1)));
   endtask

   task automatic clear_track();
      first_acc = -1;
      first_out = -1;
      last_out  = -1;
      out_cnt   = 0;
   endtask

   // One clock cycle, entered just after a falling edge.
   task automatic step(input bit iv, input bit ordy);
      exp_t e;
      in_valid  = iv;
      out_ready = ordy;
      in_xm_re  = DW'(d_xmr);
      in_xm_im  = DW'(d_xmi);
      in_xn_re  = DW'(d_xnr);
      in_xn_im  = DW'(d_xni);
      tw_re     = TW'(d_twr);
      tw_im     = TW'(d_twi);
      in_scale  = d_sc;
      #1;
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (stall_hold) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_data", out_word(), held);
      end
      if (in_valid && in_ready) begin
         sb.push_back(use_ov ? ov : model(d_xmr, d_xmi, d_xnr, d_xni, d_twr, d_twi, d_sc));
         if (first_acc < 0) first_acc = cyc;
      end
      if (out_valid) begin
         if (first_out < 0) first_out = cyc;
         last_out = cyc;
         out_cnt++;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_out", out_valid, 1'b0);
         end else begin
            e = sb.pop_front();
            chk("xm_re", out_xm_re, DW'(e.xr));
            chk("xm_im", out_xm_im, DW'(e.xi));
            chk("xn_re", out_xn_re, DW'(e.nr));
            chk("xn_im", out_xn_im, DW'(e.ni));
            chk("out_sat", out_sat, e.sat);
         end
      end
      stall_hold = out_valid && !out_ready;
      held       = out_word();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() > 0; i++) step(1'b0, 1'b1);
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      in_xm_re = '0; in_xm_im = '0; in_xn_re = '0; in_xn_im = '0;
      tw_re = '0; tw_im = '0; in_scale = 1'b0;
      set_data(0, 0, 0, 0, 0, 0, 1'b0);
      use_ov = 1'b0; stall_hold = 1'b0; held = '0; cyc = 0;
      clear_track();

      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_outputs", out_word(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Exact -j twiddle, unscaled and scaled
      set_data(50, 20, 100, 0, 0, -2048, 1'b0);
      use_ov = 1'b1; ov = '{50, -80, 50, 120, 1'b0};
      step(1'b1, 1'b1);
      set_data(50, 20, 100, 0, 0, -2048, 1'b1);
      ov = '{25, -40, 25, 60, 1'b0};
      step(1'b1, 1'b1);
      use_ov = 1'b0;
      drain();
      chk("ovf_clean", ovf, 1'b0);

      // Saturation, unscaled then scaled
      set_data(2047, 0, 2047, 0, 2047, 0, 1'b0);
      use_ov = 1'b1; ov = '{2047, 0, 1, 0, 1'b1};
      step(1'b1, 1'b1);
      use_ov = 1'b0;
      drain();
      chk("ovf_set", ovf, 1'b1);
      set_data(2047, 0, 2047, 0, 2047, 0, 1'b1);
      use_ov = 1'b1; ov = '{2047, 0, 1, 0, 1'b0};
      step(1'b1, 1'b1);
      use_ov = 1'b0;
      drain();

      // Streaming: 16 back-to-back pairs
      clear_track();
      for (int i = 0; i < 16; i++) begin
         rand_data();
         step(1'b1, 1'b1);
      end
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
      chk("stream_latency", first_out - first_acc, 3);
      chk("stream_span", last_out - first_out, 15);
      chk("stream_count", out_cnt, 16);
      chk("stream_empty", sb.size(), 0);

      // Random backpressure
      for (int i = 0; i < 300; i++) begin
         rand_data();
         step($urandom_range(0, 9) < 6, $urandom_range(0, 9) >= 3);
      end
      drain();

      // Sticky flag: clear collides with a saturating load, then clear alone
      set_data(2047, 2047, 2047, 2047, 2047, 0, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      ovf_clr = 1'b1;
      step(1'b0, 1'b1);
      ovf_clr = 1'b0;
      chk("ovf_set_wins", ovf, 1'b1);
      ovf_clr = 1'b1;
      step(1'b0, 1'b1);
      ovf_clr = 1'b0;
      chk("ovf_cleared", ovf, 1'b0);
      drain();

      // Reset with three samples in flight
      set_data(-2048, 0, 2047, 0, -2048, 0, 1'b0);
      step(1'b1, 1'b0);
      rand_data();
      step(1'b1, 1'b0);
      rand_data();
      step(1'b1, 1'b0);
      chk("pre_rst_valid", out_valid, 1'b1);
      chk("pre_rst_ovf", ovf, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_ovf", ovf, 1'b0);
      chk("midrst_outputs", out_word(), 64'd0);
      sb.delete();
      stall_hold = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_track();
      rand_data();
      step(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
      chk("post_rst_latency", first_out - first_acc, 3);
      chk("post_rst_count", out_cnt, 1);
      chk("post_rst_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
